// File: rtl/mips16_pkg.sv
// Shared types and sizes for the mips16 single-cycle core and its data-memory path.
package mips16_pkg;
  localparam int DMEM_ADDR_W = 6;
  localparam int DATA_W      = 16;
  localparam int LOCK_CNT_W  = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;
endpackage

// File: rtl/arb_rd_return.sv
// Per-port read-return register: captures memory data on a granted read; data valid 1 cycle later.
// No backpressure: rvalid is a single-cycle pulse and rdata holds until that port's next read.
module arb_rd_return #(
  parameter int DATA_W = mips16_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) rdata <= mem_rdata;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin CPU/debug arbiter for the single-port data memory; 0-cycle grant, 1-cycle read data.
// Losing requester is stalled and must hold its fields; debug may lock the memory for up to LOCK_MAX grants.
module dmem_arbiter #(
  parameter int ADDR_W   = mips16_pkg::DMEM_ADDR_W,
  parameter int DATA_W   = mips16_pkg::DATA_W,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import mips16_pkg::*;

  arb_state_t            state, state_nxt;
  logic                  last_dbg, last_dbg_nxt;
  logic [LOCK_CNT_W-1:0] lock_cnt, lock_cnt_nxt, lock_cnt_inc;
  logic                  lock_full;

  // lock_cnt counts debug grants in the current burst, including the one that took the lock
  assign lock_cnt_inc = lock_cnt + 1'b1;
  assign lock_full    = (lock_cnt_inc == LOCK_CNT_W'(LOCK_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      last_dbg <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_dbg <= last_dbg_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_dbg_nxt = last_dbg;
    lock_cnt_nxt = lock_cnt;
    cpu_gnt      = 1'b0;
    dbg_gnt      = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (cpu_req && dbg_req) begin
          cpu_gnt      = last_dbg;
          dbg_gnt      = ~last_dbg;
          last_dbg_nxt = ~last_dbg;
        end else begin
          cpu_gnt = cpu_req;
          dbg_gnt = dbg_req;
        end
        if (dbg_gnt && dbg_lock) begin
          // a one-grant limit is exhausted by the grant that asked for the lock
          if (LOCK_MAX == 1) begin
            last_dbg_nxt = 1'b1;
          end else begin
            state_nxt    = ARB_LOCKED;
            lock_cnt_nxt = LOCK_CNT_W'(1);
          end
        end
      end
      ARB_LOCKED: begin
        dbg_gnt      = dbg_req;
        lock_cnt_nxt = lock_cnt_inc;
        if (lock_full) last_dbg_nxt = 1'b1;
        if (lock_full || !dbg_lock) begin
          state_nxt    = ARB_IDLE;
          lock_cnt_nxt = '0;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
    if (!rst_n) begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_re    = ~cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_re    = ~dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  arb_rd_return #(.DATA_W(DATA_W)) u_cpu_rd (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (cpu_gnt & ~cpu_we),
    .mem_rdata (mem_rdata),
    .rvalid    (cpu_rvalid),
    .rdata     (cpu_rdata)
  );

  arb_rd_return #(.DATA_W(DATA_W)) u_dbg_rd (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (dbg_gnt & ~dbg_we),
    .mem_rdata (mem_rdata),
    .rvalid    (dbg_rvalid),
    .rdata     (dbg_rdata)
  );
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, lock/reset sequences, then randomized traffic vs a reference model.
module tb_dmem_arbiter;
  import mips16_pkg::*;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int LM = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Data memory: combinational read, write at the edge; init_req reloads the known image
  logic [DW-1:0] mem [64];
  logic          init_req = 1'b0;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'hA000 | 16'(i);
      mem[1] <= 16'h5678;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [60:0] outs();
    return {cpu_gnt, cpu_stall, dbg_gnt, mem_we, mem_re, mem_addr, mem_wdata,
            cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata};
  endfunction

  typedef struct {
    logic          creq, cwe;
    logic [AW-1:0] caddr;
    logic          dreq, dwe;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwd;
    logic          cgnt, dgnt, mwe, mre;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwd;
    logic          crv;
    logic [DW-1:0] crd;
    logic          drv;
    logic [DW-1:0] drd;
  } vec_t;

  vec_t vecs[13];

  // Reference model: who owns the memory, how long the debug burst has run, whose turn it is
  bit            m_dbg_owns;
  int            m_burst;
  bit            m_cpu_next;
  logic [DW-1:0] ref_mem [64];
  logic          e_crv, e_drv;
  logic [DW-1:0] e_crd, e_drd;

  task automatic model_reset();
    m_dbg_owns = 0; m_burst = 0; m_cpu_next = 0;
    e_crv = 0; e_drv = 0; e_crd = '0; e_drd = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'hA000 | 16'(i);
    ref_mem[1] = 16'h5678;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; init_req = 1'b1;
    @(posedge clk); #1 init_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
  endtask

  initial begin
    logic eg_c, eg_d, ew, er;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    bit c_hold, d_hold, lock_mode;
    int first_cgnt, n_stall, n_dgnt;
    logic seen_last;

    vecs[0] = '{1'b1,1'b0,6'd1, 1'b0,1'b0,6'd0,16'h0, 1'b1,1'b0,1'b0,1'b1,6'd1,16'h0,    1'b0,16'h0,   1'b0,16'h0};
    vecs[1] = '{1'b1,1'b0,6'd2, 1'b1,1'b0,6'd3,16'h0, 1'b0,1'b1,1'b0,1'b1,6'd3,16'h0,    1'b1,16'h5678,1'b0,16'h0};
    vecs[2] = '{1'b1,1'b0,6'd2, 1'b1,1'b0,6'd4,16'h0, 1'b1,1'b0,1'b0,1'b1,6'd2,16'h0,    1'b0,16'h5678,1'b1,16'hA003};
    vecs[3] = '{1'b1,1'b0,6'd6, 1'b1,1'b0,6'd4,16'h0, 1'b0,1'b1,1'b0,1'b1,6'd4,16'h0,    1'b1,16'hA002,1'b0,16'hA003};
    vecs[4] = '{1'b1,1'b0,6'd6, 1'b1,1'b0,6'd7,16'h0, 1'b1,1'b0,1'b0,1'b1,6'd6,16'h0,    1'b0,16'hA002,1'b1,16'hA004};
    vecs[5] = '{1'b0,1'b0,6'd0, 1'b1,1'b0,6'd7,16'h0, 1'b0,1'b1,1'b0,1'b1,6'd7,16'h0,    1'b1,16'hA006,1'b0,16'hA004};
    vecs[6] = '{1'b0,1'b0,6'd0, 1'b1,1'b1,6'd5,16'hBEEF, 1'b0,1'b1,1'b1,1'b0,6'd5,16'hBEEF, 1'b0,16'hA006,1'b1,16'hA007};
    vecs[7] = '{1'b1,1'b0,6'd5, 1'b0,1'b0,6'd0,16'h0, 1'b1,1'b0,1'b0,1'b1,6'd5,16'h0,    1'b0,16'hA006,1'b0,16'hA007};
    vecs[8] = '{1'b0,1'b0,6'd0, 1'b0,1'b0,6'd0,16'h0, 1'b0,1'b0,1'b0,1'b0,6'd0,16'h0,    1'b1,16'hBEEF,1'b0,16'hA007};
    for (int i = 9; i < 13; i++)
      vecs[i] = '{1'b0,1'b0,6'd0, 1'b0,1'b0,6'd0,16'h0, 1'b0,1'b0,1'b0,1'b0,6'd0,16'h0, 1'b0,16'hBEEF,1'b0,16'hA007};

    // Reset with both ports requesting writes: nothing may reach the memory
    idle_inputs();
    cpu_req = 1; cpu_we = 1; cpu_addr = 6'd9; dbg_req = 1; dbg_we = 1; dbg_addr = 6'd10;
    rst_n = 1'b1;
    #1 rst_n = 1'b0; init_req = 1'b1;
    @(posedge clk); #1 init_req = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          64'({cpu_gnt, dbg_gnt, mem_we, mem_re, mem_addr, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata}),
          64'(0));
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b1;

    // Directed table: read after reset, contention, debug write then CPU read, idle
    for (int i = 0; i < 13; i++) begin
      cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe; cpu_addr = vecs[i].caddr; cpu_wdata = '0;
      dbg_req = vecs[i].dreq; dbg_we = vecs[i].dwe; dbg_addr = vecs[i].daddr; dbg_wdata = vecs[i].dwd;
      dbg_lock = 0;
      @(negedge clk);
      check($sformatf("vec%0d", i), 64'(outs()),
            64'({vecs[i].cgnt, vecs[i].creq & ~vecs[i].cgnt, vecs[i].dgnt, vecs[i].mwe, vecs[i].mre,
                 vecs[i].maddr, vecs[i].mwd, vecs[i].crv, vecs[i].crd, vecs[i].drv, vecs[i].drd}));
      @(posedge clk); #1;
    end

    // Debug lock held for 20 cycles against a continuous CPU request
    idle_inputs();
    do_reset();
    cpu_req = 1; cpu_addr = 6'd8; dbg_req = 1; dbg_addr = 6'd9; dbg_lock = 1;
    first_cgnt = -1; n_stall = 0; n_dgnt = 0; seen_last = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (first_cgnt < 0) begin
        if (cpu_gnt) begin
          first_cgnt = i;
          seen_last = u_dut.last_dbg;
        end
        if (cpu_stall) n_stall++;
        if (dbg_gnt) n_dgnt++;
      end
      @(posedge clk); #1;
    end
    check("lock_stall_cycles", 64'(n_stall), 64'(8));
    check("lock_release_cycle", 64'(first_cgnt), 64'(8));
    check("lock_dbg_grants", 64'(n_dgnt), 64'(8));
    check("lock_forced_last_dbg", 64'(seen_last), 64'(1));

    // Asynchronous reset while locked at lock_cnt 3
    idle_inputs();
    do_reset();
    dbg_req = 1; dbg_addr = 6'd2; dbg_lock = 1;
    repeat (3) @(posedge clk);
    #2;
    check("midlock_cnt", 64'(u_dut.lock_cnt), 64'(3));
    check("midlock_rvalid_before", 64'(dbg_rvalid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("midlock_state_idle", 64'(u_dut.state), 64'(ARB_IDLE));
    check("midlock_reset_outs", 64'({cpu_gnt, dbg_gnt, dbg_rvalid, mem_re}), 64'(0));
    dbg_req = 0; cpu_req = 1; cpu_addr = 6'd1;
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_cpu_gnt", 64'({cpu_gnt, mem_re, mem_addr}), 64'({1'b1, 1'b1, 6'd1}));
    @(posedge clk); #1;
    @(negedge clk);
    check("post_reset_cpu_rdata", 64'({cpu_rvalid, cpu_rdata}), 64'({1'b1, 16'h5678}));
    @(posedge clk); #1;

    // Randomized traffic against the reference model
    idle_inputs();
    do_reset();
    model_reset();
    c_hold = 0; d_hold = 0; lock_mode = 0;
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) lock_mode = ($urandom_range(0, 1) == 1);
      if (!c_hold) begin
        cpu_req = ($urandom_range(0, 3) != 0); cpu_we = ($urandom_range(0, 2) == 0);
        cpu_addr = 6'($urandom_range(0, 63)); cpu_wdata = 16'($urandom);
      end
      if (!d_hold) begin
        dbg_req = ($urandom_range(0, 2) != 0); dbg_we = ($urandom_range(0, 2) == 0);
        dbg_addr = 6'($urandom_range(0, 63)); dbg_wdata = 16'($urandom);
      end
      dbg_lock = lock_mode ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 7) == 0);
      @(negedge clk);
      if (m_dbg_owns) begin
        eg_c = 0; eg_d = dbg_req;
      end else if (cpu_req && dbg_req) begin
        eg_c = m_cpu_next; eg_d = !m_cpu_next;
      end else begin
        eg_c = cpu_req; eg_d = dbg_req;
      end
      ew = 0; er = 0; ea = '0; ewd = '0;
      if (eg_c) begin ew = cpu_we; er = !cpu_we; ea = cpu_addr; ewd = cpu_wdata; end
      else if (eg_d) begin ew = dbg_we; er = !dbg_we; ea = dbg_addr; ewd = dbg_wdata; end
      check($sformatf("rand%0d", i), 64'(outs()),
            64'({eg_c, cpu_req & ~eg_c, eg_d, ew, er, ea, ewd, e_crv, e_crd, e_drv, e_drd}));
      @(posedge clk);
      e_crv = eg_c && !cpu_we;
      if (e_crv) e_crd = ref_mem[cpu_addr];
      e_drv = eg_d && !dbg_we;
      if (e_drv) e_drd = ref_mem[dbg_addr];
      if (eg_c && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      if (eg_d && dbg_we) ref_mem[dbg_addr] = dbg_wdata;
      if (m_dbg_owns) begin
        m_burst++;
        if (m_burst >= LM) begin
          m_dbg_owns = 0; m_burst = 0; m_cpu_next = 1;
        end else if (!dbg_lock) begin
          m_dbg_owns = 0; m_burst = 0;
        end
      end else begin
        if (cpu_req && dbg_req) m_cpu_next = eg_d;
        if (eg_d && dbg_lock) begin m_dbg_owns = 1; m_burst = 1; end
      end
      c_hold = cpu_req && !eg_c;
      d_hold = dbg_req && !eg_d;
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
